// File: rtl/lsu_if.sv
// lsu_if -- bundle of the load/store unit's pipeline handshakes and memory bus.
//
// Handshake semantics (both pipeline sides): a transfer happens on a rising
// clock edge where valid and ready are both 1. A producer holding valid keeps
// its payload stable until that edge. The memory side uses req/ack in the same
// way: req stays high with address/data/mask/we stable until the edge where ack
// is seen.
//
// Signals:
//   i_sys_valid / o_sys_ready        EXU -> LSU instruction handshake
//   o_sys_valid / i_sys_ready        LSU -> WBU result handshake
//   i_idu_ctr_ram_rd_en/_wr_en/_byt  load/store select and access size
//   i_exu_res, i_gpr_rs2_data        effective address, store data
//   o_ram_req/_we/_addr/_wr_data/_wr_mask, i_ram_ack, i_ram_rd_data  memory bus
//   o_lsu_ram_res, o_lsu_misalign    result to WBU
// Modports: slave = the LSU itself, master = the surrounding pipeline/memory.
interface lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_sys_valid;
    logic                  o_sys_ready;
    logic                  o_sys_valid;
    logic                  i_sys_ready;
    logic                  i_idu_ctr_ram_rd_en;
    logic                  i_idu_ctr_ram_wr_en;
    logic [2:0]            i_idu_ctr_ram_byt;
    logic [ADDR_WIDTH-1:0] i_exu_res;
    logic [DATA_WIDTH-1:0] i_gpr_rs2_data;
    logic                  o_ram_req;
    logic                  o_ram_we;
    logic [ADDR_WIDTH-1:0] o_ram_addr;
    logic [DATA_WIDTH-1:0] o_ram_wr_data;
    logic [3:0]            o_ram_wr_mask;
    logic                  i_ram_ack;
    logic [DATA_WIDTH-1:0] i_ram_rd_data;
    logic [DATA_WIDTH-1:0] o_lsu_ram_res;
    logic                  o_lsu_misalign;

    modport slave (
        input  i_sys_valid, i_sys_ready, i_idu_ctr_ram_rd_en, i_idu_ctr_ram_wr_en,
               i_idu_ctr_ram_byt, i_exu_res, i_gpr_rs2_data, i_ram_ack, i_ram_rd_data,
        output o_sys_ready, o_sys_valid, o_ram_req, o_ram_we, o_ram_addr,
               o_ram_wr_data, o_ram_wr_mask, o_lsu_ram_res, o_lsu_misalign
    );

    modport master (
        output i_sys_valid, i_sys_ready, i_idu_ctr_ram_rd_en, i_idu_ctr_ram_wr_en,
               i_idu_ctr_ram_byt, i_exu_res, i_gpr_rs2_data, i_ram_ack, i_ram_rd_data,
        input  o_sys_ready, o_sys_valid, o_ram_req, o_ram_we, o_ram_addr,
               o_ram_wr_data, o_ram_wr_mask, o_lsu_ram_res, o_lsu_misalign
    );
endinterface

// File: rtl/lsu.sv
// lsu -- load/store unit between EXU and WBU.
//
// Accepts one instruction at a time in IDLE, issues at most one word-aligned
// memory access (REQ), then presents the result in DONE until WBU takes it.
// Misaligned accesses never reach the bus; they complete with o_lsu_misalign.
// Every output is a register.
//
// Ports:
//   i_sys_clk    rising-edge clock
//   i_sys_rst_n  asynchronous active-low reset
//   bus          lsu_if.slave (pipeline handshakes + memory bus)
//   o_dbg_state  current FSM state (0=IDLE, 1=REQ, 2=DONE)
//
// Byte-lane logic assumes a 32-bit data path (4 lanes).
module lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst_n,
    lsu_if.slave       bus,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e state;

    // Latched access attributes needed when the read word comes back.
    logic [1:0] off_q;
    logic [1:0] size_q;     // 0=byte, 1=half, 2=word
    logic       signed_q;
    logic       load_q;

    // Decode of the incoming instruction.
    logic [1:0]            in_size;
    logic                  in_signed;
    logic [1:0]            in_off;
    logic                  in_mem;
    logic                  in_misalign;
    logic [3:0]            in_mask;
    logic [DATA_WIDTH-1:0] in_wdata;

    always_comb begin
        in_size   = 2'd2;
        in_signed = 1'b0;
        case (bus.i_idu_ctr_ram_byt)
            3'd0:    begin in_size = 2'd0; in_signed = 1'b1; end
            3'd1:    begin in_size = 2'd1; in_signed = 1'b1; end
            3'd4:    in_size = 2'd0;
            3'd5:    in_size = 2'd1;
            default: in_size = 2'd2;  // W and all unlisted codes
        endcase
        in_off      = bus.i_exu_res[1:0];
        in_mem      = bus.i_idu_ctr_ram_rd_en | bus.i_idu_ctr_ram_wr_en;
        in_misalign = ((in_size == 2'd1) && in_off[0]) ||
                      ((in_size == 2'd2) && (in_off != 2'd0));
        case (in_size)
            2'd0: begin
                in_mask  = 4'b0001 << in_off;
                in_wdata = {4{bus.i_gpr_rs2_data[7:0]}};
            end
            2'd1: begin
                in_mask  = 4'b0011 << in_off;
                in_wdata = {2{bus.i_gpr_rs2_data[15:0]}};
            end
            default: begin
                in_mask  = 4'b1111;
                in_wdata = bus.i_gpr_rs2_data;
            end
        endcase
    end

    // Extraction of the load result from the returned word.
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] ld_res;

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = bus.i_ram_rd_data[7:0];
            2'd1:    byte_sel = bus.i_ram_rd_data[15:8];
            2'd2:    byte_sel = bus.i_ram_rd_data[23:16];
            default: byte_sel = bus.i_ram_rd_data[31:24];
        endcase
        half_sel = off_q[1] ? bus.i_ram_rd_data[31:16] : bus.i_ram_rd_data[15:0];
        case (size_q)
            2'd0:    ld_res = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'd1:    ld_res = {{16{signed_q & half_sel[15]}}, half_sel};
            default: ld_res = bus.i_ram_rd_data;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state              <= ST_IDLE;
            off_q              <= 2'd0;
            size_q             <= 2'd0;
            signed_q           <= 1'b0;
            load_q             <= 1'b0;
            bus.o_sys_ready    <= 1'b1;
            bus.o_sys_valid    <= 1'b0;
            bus.o_ram_req      <= 1'b0;
            bus.o_ram_we       <= 1'b0;
            bus.o_ram_addr     <= '0;
            bus.o_ram_wr_data  <= '0;
            bus.o_ram_wr_mask  <= 4'b0000;
            bus.o_lsu_ram_res  <= '0;
            bus.o_lsu_misalign <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_sys_valid) begin
                        off_q              <= in_off;
                        size_q             <= in_size;
                        signed_q           <= in_signed;
                        // rd+wr together behaves as a store
                        load_q             <= bus.i_idu_ctr_ram_rd_en & ~bus.i_idu_ctr_ram_wr_en;
                        bus.o_ram_addr     <= {bus.i_exu_res[ADDR_WIDTH-1:2], 2'b00};
                        bus.o_sys_ready    <= 1'b0;
                        bus.o_lsu_ram_res  <= '0;
                        if (in_mem && !in_misalign) begin
                            state              <= ST_REQ;
                            bus.o_ram_req      <= 1'b1;
                            bus.o_ram_we       <= bus.i_idu_ctr_ram_wr_en;
                            bus.o_ram_wr_data  <= bus.i_idu_ctr_ram_wr_en ? in_wdata : '0;
                            bus.o_ram_wr_mask  <= bus.i_idu_ctr_ram_wr_en ? in_mask : 4'b0000;
                            bus.o_lsu_misalign <= 1'b0;
                        end else begin
                            state              <= ST_DONE;
                            bus.o_sys_valid    <= 1'b1;
                            bus.o_lsu_misalign <= in_mem & in_misalign;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.i_ram_ack) begin
                        state             <= ST_DONE;
                        bus.o_ram_req     <= 1'b0;
                        bus.o_ram_we      <= 1'b0;
                        bus.o_sys_valid   <= 1'b1;
                        bus.o_lsu_ram_res <= load_q ? ld_res : '0;
                    end
                end
                ST_DONE: begin
                    if (bus.i_sys_ready) begin
                        state              <= ST_IDLE;
                        bus.o_sys_valid    <= 1'b0;
                        bus.o_sys_ready    <= 1'b1;
                        bus.o_lsu_ram_res  <= '0;
                        bus.o_lsu_misalign <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_dbg_state = state;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu -- directed bench for lsu with a transaction-level expectation model.
module tb_lsu;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;

  logic [32:0] exp_q[$];   // {misalign, result}
  logic [68:0] bus_q[$];   // {we, mask, addr, wdata}
  logic        busy;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(input logic [2:0] byt, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (int'(off) * 8)) & 32'hFF;
    h = (word >> (int'(off) * 8)) & 32'hFFFF;
    case (byt)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic int model_bytes(input logic [2:0] byt);
    if (byt == 3'd0 || byt == 3'd4) return 1;
    if (byt == 3'd1 || byt == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic model_aligned(input logic [2:0] byt, input logic [31:0] addr);
    return (addr % model_bytes(byt)) == 0;
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] byt, input logic [1:0] off);
    int n;
    n = model_bytes(byt);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] byt, input logic [31:0] rs2);
    case (model_bytes(byt))
      1:       return (rs2 & 32'hFF) * 32'h0101_0101;
      2:       return (rs2 & 32'hFFFF) * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("sys_ready", bus.o_sys_ready, !busy);
      if (bus.o_sys_valid) begin
        if (exp_q.size() == 0) check("unexpected_valid", bus.o_sys_valid, 1'b0);
        else check("result", {bus.o_lsu_misalign, bus.o_lsu_ram_res}, exp_q[0]);
      end
      if (bus.o_ram_req) begin
        if (bus_q.size() == 0) check("unexpected_req", bus.o_ram_req, 1'b0);
        else if (bus_q[0][68])
          check("store_bus", {bus.o_ram_we, bus.o_ram_wr_mask, bus.o_ram_addr, bus.o_ram_wr_data},
                bus_q[0]);
        else
          check("load_bus", {bus.o_ram_we, bus.o_ram_addr}, {bus_q[0][68], bus_q[0][63:32]});
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      if (bus.i_sys_valid && bus.o_sys_ready) busy <= 1'b1;
      if (bus.o_sys_valid && bus.i_sys_ready) begin
        busy <= 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (bus.o_ram_req && bus.i_ram_ack && bus_q.size() > 0) void'(bus_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // ack_at: request cycle (1 = first) in which memory acks; ready_wait: cycles
  // WBU stalls after the result appears.
  task automatic run_instr(input string tag, input logic rd, input logic wr,
                           input logic [2:0] byt, input logic [31:0] addr,
                           input logic [31:0] rs2, input logic [31:0] rdata,
                           input int ack_at, input int ready_wait);
    logic mem;
    logic al;
    logic [31:0] res;
    int cyc;
    int reqs;
    mem = rd | wr;
    al  = model_aligned(byt, addr);
    res = (mem && al && !wr) ? model_load(byt, addr[1:0], rdata) : 32'd0;
    exp_q.push_back({mem && !al, res});
    if (mem && al)
      bus_q.push_back({wr, wr ? model_mask(byt, addr[1:0]) : 4'b0000, addr & 32'hFFFF_FFFC,
                       wr ? model_wdata(byt, rs2) : 32'd0});
    @(negedge clk);
    bus.i_sys_valid         = 1'b1;
    bus.i_idu_ctr_ram_rd_en = rd;
    bus.i_idu_ctr_ram_wr_en = wr;
    bus.i_idu_ctr_ram_byt   = byt;
    bus.i_exu_res           = addr;
    bus.i_gpr_rs2_data      = rs2;
    bus.i_ram_rd_data       = rdata;
    @(negedge clk);
    bus.i_sys_valid = 1'b0;
    cyc  = 1;
    reqs = 0;
    while (!bus.o_sys_valid && cyc < 40) begin
      bus.i_ram_ack = 1'b0;
      if (bus.o_ram_req) begin
        reqs++;
        if (reqs >= ack_at) bus.i_ram_ack = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.i_ram_ack = 1'b0;
    check({tag, "_valid_seen"}, bus.o_sys_valid, 1'b1);
    check({tag, "_latency"}, cyc, (mem && al) ? 1 + ack_at : 1);
    check({tag, "_req_cycles"}, reqs, (mem && al) ? ack_at : 0);
    repeat (ready_wait) @(negedge clk);
    bus.i_sys_ready = 1'b1;
    @(negedge clk);
    bus.i_sys_ready = 1'b0;
    check({tag, "_back_idle"}, {bus.o_sys_valid, dbg_state}, 3'b000);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {bus.o_sys_ready, bus.o_sys_valid, bus.o_ram_req, bus.o_ram_we, bus.o_ram_addr,
                bus.o_ram_wr_data, bus.o_ram_wr_mask, bus.o_lsu_ram_res, bus.o_lsu_misalign,
                dbg_state},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0, 2'd0});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n                   = 1'b0;
    bus.i_sys_valid         = 1'b0;
    bus.i_sys_ready         = 1'b0;
    bus.i_idu_ctr_ram_rd_en = 1'b0;
    bus.i_idu_ctr_ram_wr_en = 1'b0;
    bus.i_idu_ctr_ram_byt   = 3'd0;
    bus.i_exu_res           = 32'd0;
    bus.i_gpr_rs2_data      = 32'd0;
    bus.i_ram_ack           = 1'b0;
    bus.i_ram_rd_data       = 32'd0;

    // pin the model with hand-computed values
    check("pin_lb",   model_load(3'd0, 2'd3, 32'h80AA_BBCC), 32'hFFFF_FF80);
    check("pin_lhu",  model_load(3'd5, 2'd0, 32'h0000_F00D), 32'h0000_F00D);
    check("pin_lh",   model_load(3'd1, 2'd2, 32'h8001_1234), 32'hFFFF_8001);
    check("pin_mask", model_mask(3'd1, 2'd2), 4'b1100);
    check("pin_wdat", model_wdata(3'd1, 32'h1234_5678), 32'h5678_5678);
    check("pin_algn", model_aligned(3'd2, 32'h8000_0002), 1'b0);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;

    //          tag    rd    wr    byt   addr           rs2            rdata          ack rdy
    run_instr("lb",   1'b1, 1'b0, 3'd0, 32'h8000_0003, 32'h0,         32'h80AA_BBCC, 2, 0);
    run_instr("sh",   1'b0, 1'b1, 3'd1, 32'h8000_0002, 32'h1234_5678, 32'h0,         1, 0);
    run_instr("lw_mis", 1'b1, 1'b0, 3'd2, 32'h8000_0002, 32'h0,       32'hFFFF_FFFF, 1, 0);
    run_instr("lhu",  1'b1, 1'b0, 3'd5, 32'h8000_0000, 32'h0,         32'h0000_F00D, 3, 2);
    run_instr("nomem", 1'b0, 1'b0, 3'd2, 32'h8000_0001, 32'h5555_5555, 32'h0,        1, 0);
    run_instr("lbu",  1'b1, 1'b0, 3'd4, 32'h8000_0001, 32'h0,         32'h1234_8056, 1, 1);
    run_instr("lh",   1'b1, 1'b0, 3'd1, 32'h8000_0002, 32'h0,         32'h8001_1234, 1, 0);
    run_instr("sb",   1'b0, 1'b1, 3'd0, 32'h8000_0001, 32'hDEAD_BEEF, 32'h0,         2, 0);
    run_instr("sw",   1'b0, 1'b1, 3'd2, 32'h8000_0004, 32'hCAFE_F00D, 32'h0,         1, 3);
    run_instr("rdwr", 1'b1, 1'b1, 3'd2, 32'h8000_0008, 32'h0BAD_CAFE, 32'h1111_1111, 1, 0);
    run_instr("lw",   1'b1, 1'b0, 3'd2, 32'h8000_000C, 32'h0,         32'h1357_9BDF, 4, 0);
    run_instr("byt3_mis", 1'b1, 1'b0, 3'd3, 32'h8000_0001, 32'h0,     32'h2468_ACE0, 1, 0);
    run_instr("sh_mis", 1'b0, 1'b1, 3'd1, 32'h8000_0001, 32'h1234_5678, 32'h0,       1, 0);
    run_instr("lh_pos", 1'b1, 1'b0, 3'd1, 32'h8000_0000, 32'h0,       32'hFFFF_7FFF, 1, 1);

    // reset while a request is outstanding; a late ack must be ignored
    exp_q.push_back({1'b0, 32'hAAAA_5555});
    bus_q.push_back({1'b0, 4'b0000, 32'h8000_0010, 32'd0});
    @(negedge clk);
    bus.i_sys_valid         = 1'b1;
    bus.i_idu_ctr_ram_rd_en = 1'b1;
    bus.i_idu_ctr_ram_wr_en = 1'b0;
    bus.i_idu_ctr_ram_byt   = 3'd2;
    bus.i_exu_res           = 32'h8000_0010;
    bus.i_ram_rd_data       = 32'hAAAA_5555;
    @(negedge clk);
    bus.i_sys_valid = 1'b0;
    check("rst_pre_req", {bus.o_ram_req, dbg_state}, 3'b101);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    exp_q.delete();
    bus_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_ram_ack = 1'b1;
    @(negedge clk);
    bus.i_ram_ack = 1'b0;
    check_reset_outputs("rst_late_ack");
    @(negedge clk);
    check_reset_outputs("rst_settled");

    // still functional after the abandoned request
    run_instr("post_rst", 1'b1, 1'b0, 3'd0, 32'h8000_0002, 32'h0,     32'h007F_0000, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
